// File: rtl/alarm_snooze_ctrl.sv
// alarm_snooze_ctrl: turns an alarm match into a ringing session with beep gating, bounded snooze and auto-silence
module alarm_snooze_ctrl #(
  parameter int SNOOZE_SEC = 300,
  parameter int RING_SEC   = 60,
  parameter int MAX_SNOOZE = 3,
  parameter int TW         = 9,
  parameter int SCW        = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick_1hz,
  input  logic           alarm_en,
  input  logic           alarm_match,
  input  logic           snooze_btn,
  input  logic           stop_btn,
  output logic           buzz,
  output logic           ringing,
  output logic           snoozing,
  output logic [SCW-1:0] snooze_cnt,
  output logic [TW-1:0]  sec_left
);
  typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] sec_q, sec_d;
  logic [SCW-1:0] cnt_q, cnt_d;
  logic beep_q, beep_d, match_q, buzz_q, ringing_q, snoozing_q;
  logic [2:0] snz_q, stp_q;
  logic snz_edge, stp_edge, m_edge;
  assign snz_edge = snz_q[1] & ~snz_q[2];
  assign stp_edge = stp_q[1] & ~stp_q[2];
  assign m_edge = alarm_match & ~match_q;
  always_comb begin
    state_d = state_q;
    sec_d = sec_q;
    cnt_d = cnt_q;
    beep_d = beep_q;
    if (state_q == IDLE) begin
      if (m_edge && alarm_en) begin
        state_d = RING;
        sec_d = TW'(RING_SEC);
        cnt_d = '0;
        beep_d = 1'b1;
      end
    end else if (!alarm_en || stp_edge) begin
      state_d = IDLE;
      sec_d = '0;
      cnt_d = '0;
      beep_d = 1'b0;
    end else if (snz_edge) begin
      if (state_q == RING && cnt_q < SCW'(MAX_SNOOZE)) begin
        state_d = SNOOZE;
        sec_d = TW'(SNOOZE_SEC);
        cnt_d = cnt_q + SCW'(1);
      end
    end else if (tick_1hz) begin
      if (state_q == RING) begin
        beep_d = ~beep_q;
        if (sec_q == TW'(1)) begin
          state_d = IDLE;
          sec_d = '0;
          cnt_d = '0;
          beep_d = 1'b0;
        end else sec_d = sec_q - TW'(1);
      end else if (sec_q == TW'(1)) begin
        state_d = RING;
        sec_d = TW'(RING_SEC);
        beep_d = 1'b1;
      end else sec_d = sec_q - TW'(1);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sec_q <= '0;
      cnt_q <= '0;
      beep_q <= 1'b0;
      match_q <= 1'b1;
      snz_q <= '0;
      stp_q <= '0;
      buzz_q <= 1'b0;
      ringing_q <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_q <= sec_d;
      cnt_q <= cnt_d;
      beep_q <= beep_d;
      match_q <= alarm_match;
      snz_q <= {snz_q[1:0], snooze_btn};
      stp_q <= {stp_q[1:0], stop_btn};
      buzz_q <= (state_d == RING) & beep_d;
      ringing_q <= state_d == RING;
      snoozing_q <= state_d == SNOOZE;
    end
  end
  assign buzz = buzz_q;
  assign ringing = ringing_q;
  assign snoozing = snoozing_q;
  assign snooze_cnt = cnt_q;
  assign sec_left = sec_q;
endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// tb_alarm_snooze_ctrl: table-driven check of alarm_snooze_ctrl with short RING/SNOOZE intervals
module tb_alarm_snooze_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic tick_1hz = 1'b0, alarm_en = 1'b0, alarm_match = 1'b0, snooze_btn = 1'b0, stop_btn = 1'b0;
  logic buzz, ringing, snoozing;
  logic [1:0] snooze_cnt;
  logic [8:0] sec_left;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic t, e, m, s, p;
    logic b, r, z;
    int c, sec;
  } vec_t;
  vec_t vecs[$];
  alarm_snooze_ctrl #(.SNOOZE_SEC(5), .RING_SEC(4), .MAX_SNOOZE(2), .TW(9), .SCW(2)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .alarm_en(alarm_en), .alarm_match(alarm_match),
    .snooze_btn(snooze_btn), .stop_btn(stop_btn), .buzz(buzz), .ringing(ringing),
    .snoozing(snoozing), .snooze_cnt(snooze_cnt), .sec_left(sec_left)
  );
  always #5 clk = ~clk;
  function automatic void add(input logic t, e, m, s, p, b, r, z, input int c, sec);
    vec_t v;
    v.t = t; v.e = e; v.m = m; v.s = s; v.p = p; v.b = b; v.r = r; v.z = z; v.c = c; v.sec = sec;
    vecs.push_back(v);
  endfunction
  function automatic void chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction
  task automatic chk_all(input string nm, input logic b, r, z, input int c, sec);
    chk({nm, " buzz"}, int'(buzz), int'(b));
    chk({nm, " ringing"}, int'(ringing), int'(r));
    chk({nm, " snoozing"}, int'(snoozing), int'(z));
    chk({nm, " snooze_cnt"}, int'(snooze_cnt), c);
    chk({nm, " sec_left"}, int'(sec_left), sec);
  endtask
  initial begin
    // ring, beep toggling, auto-silence
    add(0,1,0,0,0, 0,0,0,0,0);
    add(0,1,1,0,0, 1,1,0,0,4);
    add(0,1,1,0,0, 1,1,0,0,4);
    add(1,1,1,0,0, 0,1,0,0,3);
    add(1,1,0,0,0, 1,1,0,0,2);
    add(1,1,0,0,0, 0,1,0,0,1);
    add(1,1,0,0,0, 0,0,0,0,0);
    // snooze twice, third press ignored, match inside session ignored, stop
    add(0,1,1,0,0, 1,1,0,0,4);
    add(0,1,0,1,0, 1,1,0,0,4);
    add(0,1,0,1,0, 1,1,0,0,4);
    add(0,1,0,1,0, 0,0,1,1,5);
    add(1,1,0,0,0, 0,0,1,1,4);
    add(1,1,1,0,0, 0,0,1,1,3);
    add(1,1,0,0,0, 0,0,1,1,2);
    add(1,1,0,0,0, 0,0,1,1,1);
    add(1,1,0,0,0, 1,1,0,1,4);
    add(0,1,0,1,0, 1,1,0,1,4);
    add(0,1,0,1,0, 1,1,0,1,4);
    add(0,1,0,1,0, 0,0,1,2,5);
    add(1,1,0,0,0, 0,0,1,2,4);
    add(1,1,0,0,0, 0,0,1,2,3);
    add(1,1,0,0,0, 0,0,1,2,2);
    add(1,1,0,0,0, 0,0,1,2,1);
    add(1,1,0,0,0, 1,1,0,2,4);
    add(0,1,0,1,0, 1,1,0,2,4);
    add(0,1,0,1,0, 1,1,0,2,4);
    add(0,1,0,1,0, 1,1,0,2,4);
    add(0,1,0,0,0, 1,1,0,2,4);
    add(0,1,0,0,1, 1,1,0,2,4);
    add(0,1,0,0,1, 1,1,0,2,4);
    add(0,1,0,0,1, 0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0);
    // match with alarm disabled, then enabling while match held
    add(0,0,1,0,0, 0,0,0,0,0);
    add(0,1,1,0,0, 0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0);
    // stop edge beats a tick that would end snooze
    add(0,1,1,0,0, 1,1,0,0,4);
    add(0,1,0,1,0, 1,1,0,0,4);
    add(0,1,0,1,0, 1,1,0,0,4);
    add(0,1,0,1,0, 0,0,1,1,5);
    add(1,1,0,0,0, 0,0,1,1,4);
    add(1,1,0,0,0, 0,0,1,1,3);
    add(1,1,0,0,0, 0,0,1,1,2);
    add(1,1,0,0,0, 0,0,1,1,1);
    add(0,1,0,0,1, 0,0,1,1,1);
    add(0,1,0,0,1, 0,0,1,1,1);
    add(1,1,0,0,1, 0,0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0,0);
    // dropping alarm_en in snooze
    add(0,1,1,0,0, 1,1,0,0,4);
    add(0,1,0,1,0, 1,1,0,0,4);
    add(0,1,0,1,0, 1,1,0,0,4);
    add(0,1,0,1,0, 0,0,1,1,5);
    add(0,0,0,0,0, 0,0,0,0,0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    #1 chk_all("reset", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      {tick_1hz, alarm_en, alarm_match, snooze_btn, stop_btn} = {vecs[i].t, vecs[i].e, vecs[i].m, vecs[i].s, vecs[i].p};
      @(posedge clk);
      #1 chk_all($sformatf("row%0d", i), vecs[i].b, vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].sec);
    end
    {tick_1hz, snooze_btn, stop_btn} = 3'b000;
    alarm_en = 1'b1;
    alarm_match = 1'b1;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all("match_thru_rst", 0, 0, 0, 0, 0);
    alarm_match = 1'b0;
    @(posedge clk);
    #1 alarm_match = 1'b1;
    @(posedge clk);
    #1 chk_all("fresh_edge", 1, 1, 0, 0, 4);
    @(negedge clk) rst = 1'b1;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_all("post_rst_hold", 0, 0, 0, 0, 0);
    alarm_match = 1'b0;
    @(posedge clk);
    #1 alarm_match = 1'b1;
    @(posedge clk);
    #1 chk_all("rearm", 1, 1, 0, 0, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
